// File: rtl/lab5_rgb_driver.sv
// rtl/lab5_rgb_driver.sv - RGB LED display stage for the lab5 2-bit comparator
//
// Synchronises and debounces the comparator's one-hot flags, shows the
// accepted result on a PWM-dimmed RGB LED and reports it in encoded form.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   r, g, bl          comparator flags a>b, a==b, a<b (asynchronous to clk)
//   led_r/led_g/led_b registered PWM LED drives
//   result            accepted code: 00 none, 01 a>b, 10 a==b, 11 a<b
//   valid             a legal result is being displayed
//   err               the last accepted pattern was not one-hot
//   changes           saturating count of displayed-result changes
module lab5_rgb_driver #(
  parameter int STABLE_CYCLES = 4,
  parameter int PWM_BITS      = 4,
  parameter int DUTY          = 8,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 r,
  input  logic                 g,
  input  logic                 bl,
  output logic                 led_r,
  output logic                 led_g,
  output logic                 led_b,
  output logic [1:0]           result,
  output logic                 valid,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] changes
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] SCNT_MAX  = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] SCNT_LAST = SW'(STABLE_CYCLES - 1);
  // One extra bit so DUTY == 2^PWM_BITS (always on) is representable.
  localparam logic [PWM_BITS:0] DUTY_W = (PWM_BITS + 1)'(DUTY);

  typedef enum logic [1:0] {IDLE, SHOW, FAULT} state_t;

  state_t              state_q, state_d;
  logic [1:0]          code_q, code_d;
  logic [2:0]          sync1, samp, cand;
  logic [SW-1:0]       scnt;
  logic [PWM_BITS-1:0] pcnt;
  logic [1:0]          cand_code;
  logic                accept, pwm_on, bump;

  // Synchroniser and glitch filter. scnt parks at STABLE_CYCLES once a
  // pattern has been accepted, so the reset pattern 000 is never accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 3'b000;
      samp  <= 3'b000;
      cand  <= 3'b000;
      scnt  <= SCNT_MAX;
    end else begin
      sync1 <= {r, g, bl};
      samp  <= sync1;
      if (samp != cand) begin
        cand <= samp;
        scnt <= '0;
      end else if (scnt != SCNT_MAX) begin
        scnt <= scnt + 1'b1;
      end
    end
  end

  assign accept = (samp == cand) && (scnt == SCNT_LAST);

  always_comb begin
    cand_code = 2'b00;
    case (cand)
      3'b100:  cand_code = 2'b01;
      3'b010:  cand_code = 2'b10;
      3'b001:  cand_code = 2'b11;
      default: cand_code = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  // cand_code == 00 marks a zero or multi-hot pattern.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    bump    = 1'b0;
    if (accept) begin
      if (cand_code != 2'b00) begin
        state_d = SHOW;
        code_d  = cand_code;
        bump    = (state_q != SHOW) || (code_q != cand_code);
      end else begin
        state_d = FAULT;
        code_d  = 2'b00;
      end
    end
  end

  assign result = code_q;
  assign valid  = (state_q == SHOW);
  assign err    = (state_q == FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changes <= '0;
    end else if (bump && (changes != {CNT_WIDTH{1'b1}})) begin
      changes <= changes + 1'b1;
    end
  end

  assign pwm_on = ({1'b0, pcnt} < DUTY_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt  <= '0;
      led_r <= 1'b0;
      led_g <= 1'b0;
      led_b <= 1'b0;
    end else begin
      pcnt  <= pcnt + 1'b1;
      led_r <= valid && (code_q == 2'b01) && pwm_on;
      led_g <= valid && (code_q == 2'b10) && pwm_on;
      led_b <= valid && (code_q == 2'b11) && pwm_on;
    end
  end

endmodule

// File: tb/tb_lab5_rgb_driver.sv
// tb/tb_lab5_rgb_driver.sv - scoreboard bench for lab5_rgb_driver
module tb_lab5_rgb_driver;

  localparam int S    = 4;
  localparam int PB   = 4;
  localparam int DUTY = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic r = 1'b0, g = 1'b0, bl = 1'b0;

  logic       led_r, led_g, led_b, valid, err;
  logic [1:0] result;
  logic [7:0] changes;
  logic       led_r2, led_g2, led_b2, valid2, err2;
  logic [1:0] result2;
  logic [1:0] changes2;

  lab5_rgb_driver #(.STABLE_CYCLES(S), .PWM_BITS(PB), .DUTY(DUTY), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .r(r), .g(g), .bl(bl),
    .led_r(led_r), .led_g(led_g), .led_b(led_b),
    .result(result), .valid(valid), .err(err), .changes(changes)
  );

  lab5_rgb_driver #(.STABLE_CYCLES(S), .PWM_BITS(PB), .DUTY(DUTY), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .r(r), .g(g), .bl(bl),
    .led_r(led_r2), .led_g(led_g2), .led_b(led_b2),
    .result(result2), .valid(valid2), .err(err2), .changes(changes2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] res;
    logic       v;
    logic       e;
    int         chg;
    int         cyc;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: tracks how many consecutive edges the synchronised
  // pattern has been seen; a run reaching S+1 edges is accepted.
  int         cyc, pcnt_m, run_len, mst, nchg, acc;
  logic [2:0] s1m, s2m, seen, run_val, led_exp;
  logic [1:0] mcode;
  exp_t       last_exp, ne;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; pcnt_m = 0; s1m = 3'b000; s2m = 3'b000;
      run_val = 3'b000; run_len = S + 2;
      mst = 0; mcode = 2'b00; nchg = 0; led_exp = 3'b000;
      last_exp = '{res: 2'b00, v: 1'b0, e: 1'b0, chg: 0, cyc: 0};
      sbq.delete();
    end else begin
      if (mst == 1 && pcnt_m < DUTY)
        led_exp = (mcode == 2'd1) ? 3'b100 : (mcode == 2'd2) ? 3'b010 : 3'b001;
      else
        led_exp = 3'b000;
      pcnt_m = (pcnt_m + 1) % (1 << PB);
      cyc++;
      seen = s2m; s2m = s1m; s1m = {r, g, bl};
      if (seen == run_val) begin
        if (run_len < S + 2) run_len++;
      end else begin
        run_val = seen;
        run_len = 1;
      end
      if (run_len == S + 1) begin
        case (run_val)
          3'b100:  acc = 1;
          3'b010:  acc = 2;
          3'b001:  acc = 3;
          default: acc = 0;
        endcase
        if (acc != 0) begin
          if (mst != 1 || mcode != 2'(acc)) nchg++;
          mst = 1; mcode = 2'(acc);
        end else begin
          mst = 2; mcode = 2'b00;
        end
        ne = '{res: (mst == 1) ? mcode : 2'b00, v: (mst == 1), e: (mst == 2),
               chg: (nchg > 255) ? 255 : nchg, cyc: cyc};
        if (ne.res != last_exp.res || ne.v != last_exp.v || ne.e != last_exp.e || ne.chg != last_exp.chg) begin
          sbq.push_back(ne);
          last_exp = ne;
        end
      end
    end
  end

  // Monitor: every visible change of the result tuple consumes one
  // scoreboard entry, including the edge at which it was due.
  exp_t obs, last_obs, got;

  always @(negedge clk) begin
    if (rst_n) begin
      obs = '{res: result, v: valid, e: err, chg: int'(changes), cyc: cyc};
      if (obs.res != last_obs.res || obs.v != last_obs.v || obs.e != last_obs.e || obs.chg != last_obs.chg) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_change: result=%0d valid=%0d err=%0d changes=%0d at edge %0d",
                   result, valid, err, changes, cyc);
        end else begin
          got = sbq.pop_front();
          chk("result", 32'(result), 32'(got.res));
          chk("valid", 32'(valid), 32'(got.v));
          chk("err", 32'(err), 32'(got.e));
          chk("changes", 32'(changes), got.chg);
          chk("accept_edge", cyc, got.cyc);
        end
        last_obs = obs;
      end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        got = sbq.pop_front();
        checks++; failures++;
        $display("FAIL missed_update: outputs unchanged, expected result=%0d valid=%0d err=%0d changes=%0d at edge %0d",
                 got.res, got.v, got.e, got.chg, got.cyc);
      end
      chk("leds", 32'({led_r, led_g, led_b}), 32'(led_exp));
      chk("changes_sat", 32'(changes2), (nchg > 3) ? 3 : nchg);
    end else begin
      last_obs = '{res: 2'b00, v: 1'b0, e: 1'b0, chg: 0, cyc: 0};
    end
  end

  task automatic drive(input logic [2:0] p, input int n);
    @(negedge clk);
    {r, g, bl} = p;
    repeat (n - 1) @(negedge clk);
  endtask

  int cnt;
  bit seen_on;

  initial begin
    last_obs = '{res: 2'b00, v: 1'b0, e: 1'b0, chg: 0, cyc: 0};
    #2 rst_n = 1'b0;
    #1;
    chk("rst_result", 32'(result), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_changes", 32'(changes), 0);
    chk("rst_leds", 32'({led_r, led_g, led_b}), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    drive(3'b000, 50);
    chk("idle_valid", 32'(valid), 0);
    chk("idle_err", 32'(err), 0);
    chk("idle_changes", 32'(changes), 0);
    chk("idle_leds", 32'({led_r, led_g, led_b}), 0);

    drive(3'b010, 30);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (led_g) cnt++;
    end
    chk("pwm_duty", cnt, DUTY);

    drive(3'b100, 3);
    drive(3'b010, 20);
    drive(3'b100, 30);

    drive(3'b110, 30);
    drive(3'b001, 30);

    drive(3'b100, 12);
    drive(3'b010, 12);
    drive(3'b001, 12);
    drive(3'b100, 12);
    drive(3'b010, 12);
    drive(3'b100, 2);
    drive(3'b010, 12);
    chk("sat_hold", 32'(changes2), 3);

    for (int k = 0; k < 40; k++)
      drive(3'($urandom_range(0, 7)), $urandom_range(1, 12));

    drive(3'b010, 12);
    seen_on = 1'b0;
    for (int i = 0; i < 40 && !seen_on; i++) begin
      @(negedge clk);
      if (led_g && valid) seen_on = 1'b1;
    end
    chk("led_g_on_before_reset", 32'(seen_on), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_led_g", 32'(led_g), 0);
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_result", 32'(result), 0);
    chk("midrst_changes", 32'(changes), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    drive(3'b010, 20);

    for (int k = 0; k < 20; k++)
      drive(3'($urandom_range(0, 7)), $urandom_range(1, 12));
    drive(3'b000, 20);
    chk("queue_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
